// File: rtl/vx_warp_sched_arb_pkg.sv
// Shared types and widths for the warp scheduler: issue record layout,
// warp-id width and default warp/thread counts (overridable with the
// NUM_WARPS / NUM_THREADS macros).
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package vx_warp_sched_arb_pkg;

  localparam int NUM_WARPS_DFLT   = `NUM_WARPS;
  localparam int NUM_THREADS_DFLT = `NUM_THREADS;
  localparam int NW_WIDTH         = (NUM_WARPS_DFLT > 1) ? $clog2(NUM_WARPS_DFLT) : 1;
  localparam int PC_BITS          = 32;
  localparam int UUID_WIDTH       = 16;
  localparam int PERF_WIDTH       = 64;

  // One issued instruction-stream slot.
  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_WIDTH-1:0]         wid;
    logic [NUM_THREADS_DFLT-1:0] tmask;
    logic [PC_BITS-1:0]          pc;
  } issue_t;

  // Next uuid, wrapping naturally at the counter width.
  function automatic logic [UUID_WIDTH-1:0] uuid_inc(input logic [UUID_WIDTH-1:0] value);
    return value + UUID_WIDTH'(1);
  endfunction

endpackage

// File: rtl/vx_warp_sched_arb_if.sv
// Issue stream from the warp scheduler: valid/ready handshake carrying one
// issue_t record. The scheduler is the master.
interface vx_warp_sched_arb_if;
  import vx_warp_sched_arb_pkg::*;

  logic   valid;
  logic   ready;
  issue_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_warp_sched_arb_rr_arbiter.sv
// Generic round-robin arbiter. The scan starts one past the last granted
// index; the pointer only advances when the consumer takes the grant.
module vx_warp_sched_arb_rr_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    grant_ready,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic                    grant_valid
);

  logic [LOG_NUM_REQS-1:0] ptr_r;
  logic [LOG_NUM_REQS-1:0] index_s;
  logic [LOG_NUM_REQS-1:0] cand_idx_s;
  logic                    found_s;
  int                      cand_s;

  // Find the first active request after the pointer, wrapping around.
  always_comb begin
    index_s    = ptr_r;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int i = 1; i <= NUM_REQS; i++) begin
      cand_s     = (int'(ptr_r) + i) % NUM_REQS;
      cand_idx_s = LOG_NUM_REQS'(cand_s);
      if (!found_s && requests[cand_idx_s]) begin
        found_s = 1'b1;
        index_s = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer follows each accepted grant; reset favours index 0 first.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= LOG_NUM_REQS'(NUM_REQS - 1);
    end else if (grant_ready && found_s) begin
      ptr_r <= index_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant_index = index_s;
  assign grant_valid = found_s;

endmodule

// File: rtl/vx_warp_sched_arb.sv
// Warp scheduler arbiter: keeps per-warp active/stalled/tmask/PC state,
// picks the next eligible warp round-robin and presents it in a one-entry
// output register with a uuid tag. A granted warp stays stalled until it is
// resumed. Optional performance counters are built when SCHED_PERF_EN is
// defined; otherwise the perf ports are tied to zero.
module vx_warp_sched_arb
  import vx_warp_sched_arb_pkg::*;
#(
  parameter int NUM_WARPS   = NUM_WARPS_DFLT,
  parameter int NUM_THREADS = NUM_THREADS_DFLT
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   spawn_valid,
  input  logic [NW_WIDTH-1:0]    spawn_wid,
  input  logic [NUM_THREADS-1:0] spawn_tmask,
  input  logic [PC_BITS-1:0]     spawn_PC,

  input  logic                   resume_valid,
  input  logic [NW_WIDTH-1:0]    resume_wid,
  input  logic [NUM_THREADS-1:0] resume_tmask,
  input  logic [PC_BITS-1:0]     resume_PC,

  vx_warp_sched_arb_if.master    schedule_if,

  output logic                   busy,
  output logic [PERF_WIDTH-1:0]  perf_stall_cycles,
  output logic [PERF_WIDTH-1:0]  perf_idle_cycles
);

  // Warp table
  logic [NUM_WARPS-1:0]   active_r;
  logic [NUM_WARPS-1:0]   stalled_r;
  logic [NUM_THREADS-1:0] tmask_r [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_r    [NUM_WARPS];
  logic [NUM_WARPS-1:0]   active_n;
  logic [NUM_WARPS-1:0]   stalled_n;
  logic [NUM_THREADS-1:0] tmask_n [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_n    [NUM_WARPS];

  // Output register and uuid counter
  logic                   valid_r;
  logic                   valid_n;
  issue_t                 data_r;
  issue_t                 data_n;
  logic [UUID_WIDTH-1:0]  uuid_r;
  logic [UUID_WIDTH-1:0]  uuid_n;
  logic                   busy_r;

  // Arbitration
  logic [NUM_WARPS-1:0]   eligible_s;
  logic [NW_WIDTH-1:0]    grant_wid_s;
  logic                   grant_valid_s;
  logic                   load_s;

  assign eligible_s = active_r & ~stalled_r;
  assign load_s     = (!valid_r || schedule_if.ready) && grant_valid_s;

  vx_warp_sched_arb_rr_arbiter #(
    .NUM_REQS     (NUM_WARPS),
    .LOG_NUM_REQS (NW_WIDTH)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .requests    (eligible_s),
    .grant_ready (load_s),
    .grant_index (grant_wid_s),
    .grant_valid (grant_valid_s)
  );

  // Per-warp next state: a taking resume beats spawn; a grant stalls the warp.
  always_comb begin
    active_n  = active_r;
    stalled_n = stalled_r;
    tmask_n   = tmask_r;
    pc_n      = pc_r;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (resume_valid && (resume_wid == NW_WIDTH'(w)) && stalled_r[w]) begin
        stalled_n[w] = 1'b0;
        active_n[w]  = |resume_tmask;
        tmask_n[w]   = resume_tmask;
        pc_n[w]      = resume_PC;
      end else if (spawn_valid && (spawn_wid == NW_WIDTH'(w)) && !active_r[w]) begin
        active_n[w]  = 1'b1;
        stalled_n[w] = 1'b0;
        tmask_n[w]   = spawn_tmask;
        pc_n[w]      = spawn_PC;
      end else if (load_s && (grant_wid_s == NW_WIDTH'(w))) begin
        stalled_n[w] = 1'b1;
      end else begin
        stalled_n[w] = stalled_r[w];
      end
    end
  end

  // Output register: load on a grant when empty or firing, drain on a bare fire.
  always_comb begin
    valid_n = valid_r;
    data_n  = data_r;
    uuid_n  = uuid_r;
    if (load_s) begin
      valid_n      = 1'b1;
      data_n.uuid  = uuid_r;
      data_n.wid   = grant_wid_s;
      data_n.tmask = tmask_r[grant_wid_s];
      data_n.pc    = pc_r[grant_wid_s];
      uuid_n       = uuid_inc(uuid_r);
    end else if (schedule_if.ready) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end
  end

  // State update; reset discards every warp and any pending issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r  <= '0;
      stalled_r <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        tmask_r[w] <= '0;
        pc_r[w]    <= '0;
      end
      valid_r <= 1'b0;
      data_r  <= '0;
      uuid_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      active_r  <= active_n;
      stalled_r <= stalled_n;
      tmask_r   <= tmask_n;
      pc_r      <= pc_n;
      valid_r   <= valid_n;
      data_r    <= data_n;
      uuid_r    <= uuid_n;
      busy_r    <= |active_n;
    end
  end

  assign schedule_if.valid = valid_r;
  assign schedule_if.data  = data_r;
  assign busy              = busy_r;

`ifdef SCHED_PERF_EN
  logic [PERF_WIDTH-1:0] stall_cnt_r;
  logic [PERF_WIDTH-1:0] idle_cnt_r;

  // Saturating counters of back-pressured and starved cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
      idle_cnt_r  <= '0;
    end else begin
      if (valid_r && !schedule_if.ready && (stall_cnt_r != {PERF_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + PERF_WIDTH'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!valid_r && busy_r && (idle_cnt_r != {PERF_WIDTH{1'b1}})) begin
        idle_cnt_r <= idle_cnt_r + PERF_WIDTH'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_r;
  assign perf_idle_cycles  = idle_cnt_r;
`else
  assign perf_stall_cycles = {PERF_WIDTH{1'b0}};
  assign perf_idle_cycles  = {PERF_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_vx_warp_sched_arb.sv
// Self-checking bench for vx_warp_sched_arb: expected issues are queued as
// spawns/resumes are driven and compared when the DUT fires.
module tb_vx_warp_sched_arb;
  import vx_warp_sched_arb_pkg::*;

  localparam int NW = NUM_WARPS_DFLT;
  localparam int NT = NUM_THREADS_DFLT;

`ifdef SCHED_PERF_EN
  localparam logic [63:0] EXP_STALL = 64'd5;
  localparam logic [63:0] EXP_IDLE  = 64'd1;
`else
  localparam logic [63:0] EXP_STALL = 64'd0;
  localparam logic [63:0] EXP_IDLE  = 64'd0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                spawn_valid;
  logic [NW_WIDTH-1:0] spawn_wid;
  logic [NT-1:0]       spawn_tmask;
  logic [PC_BITS-1:0]  spawn_pc;
  logic                resume_valid;
  logic [NW_WIDTH-1:0] resume_wid;
  logic [NT-1:0]       resume_tmask;
  logic [PC_BITS-1:0]  resume_pc;
  logic                busy;
  logic [63:0]         perf_stall_cycles;
  logic [63:0]         perf_idle_cycles;

  vx_warp_sched_arb_if sif ();

  vx_warp_sched_arb #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
    .clk               (clk),
    .reset             (reset),
    .spawn_valid       (spawn_valid),
    .spawn_wid         (spawn_wid),
    .spawn_tmask       (spawn_tmask),
    .spawn_PC          (spawn_pc),
    .resume_valid      (resume_valid),
    .resume_wid        (resume_wid),
    .resume_tmask      (resume_tmask),
    .resume_PC         (resume_pc),
    .schedule_if       (sif),
    .busy              (busy),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_idle_cycles  (perf_idle_cycles)
  );

  always #5 clk = ~clk;

  int     tests_run    = 0;
  int     tests_failed = 0;
  int     cyc          = 0;
  int     fire_cnt     = 0;
  int     exp_uuid     = 0;
  int     resume_at [NW];
  issue_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spawn_valid  = 1'b0;
    resume_valid = 1'b0;
  endtask

  task automatic push_exp(input int wid, input logic [NT-1:0] tmask, input logic [PC_BITS-1:0] pc);
    issue_t e;
    e.uuid  = UUID_WIDTH'(exp_uuid);
    e.wid   = NW_WIDTH'(wid);
    e.tmask = tmask;
    e.pc    = pc;
    exp_q.push_back(e);
    exp_uuid++;
  endtask

  task automatic do_spawn(input int wid, input logic [NT-1:0] tmask, input logic [PC_BITS-1:0] pc);
    spawn_valid = 1'b1;
    spawn_wid   = NW_WIDTH'(wid);
    spawn_tmask = tmask;
    spawn_pc    = pc;
  endtask

  task automatic do_resume(input int wid, input logic [NT-1:0] tmask, input logic [PC_BITS-1:0] pc);
    resume_valid = 1'b1;
    resume_wid   = NW_WIDTH'(wid);
    resume_tmask = tmask;
    resume_pc    = pc;
  endtask

  task automatic do_reset();
    idle_inputs();
    sif.ready = 1'b1;
    reset     = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    exp_uuid = 0;
    reset    = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: every fire is compared against the oldest expectation.
  initial begin
    issue_t e;
    for (int i = 0; i < NW; i++) resume_at[i] = -1;
    forever begin
      @(negedge clk);
      if (!reset && sif.valid && sif.ready) begin
        fire_cnt++;
        resume_at[sif.data.wid] = cyc + 2;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("uuid",  64'(sif.data.uuid),  64'(e.uuid));
          check("wid",   64'(sif.data.wid),   64'(e.wid));
          check("tmask", 64'(sif.data.tmask), 64'(e.tmask));
          check("pc",    64'(sif.data.pc),    64'(e.pc));
        end
      end
    end
  end

  initial begin
    int     f0;
    int     n_res;
    bit     hit;
    issue_t hold_exp;

    idle_inputs();
    spawn_wid    = '0;
    spawn_tmask  = '0;
    spawn_pc     = '0;
    resume_wid   = '0;
    resume_tmask = '0;
    resume_pc    = '0;
    sif.ready    = 1'b1;
    reset        = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 64'(sif.valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_data",  64'(sif.data), 64'd0);
    check("rst_stall", perf_stall_cycles, 64'd0);
    check("rst_idle",  perf_idle_cycles, 64'd0);
    reset = 1'b0;

    // Single spawn: latency and no re-issue without resume
    do_reset();
    f0 = fire_cnt;
    do_spawn(0, NT'(4'hF), 32'h8000_0000);
    push_exp(0, NT'(4'hF), 32'h8000_0000);
    tick();
    idle_inputs();
    check("spawn_lat_early", 64'(sif.valid), 64'd0);
    tick();
    check("spawn_lat_valid", 64'(sif.valid), 64'd1);
    repeat (10) tick();
    check("single_issue_count", 64'(fire_cnt - f0), 64'd1);
    check("single_busy", 64'(busy), 64'd1);

    // Round-robin over four warps, each resumed two cycles after issue
    do_reset();
    f0    = fire_cnt;
    n_res = 0;
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      if (c < 4) begin
        do_spawn(c, NT'(c + 1), 32'h0000_1000 + 32'(c * 16));
        push_exp(c, NT'(c + 1), 32'h0000_1000 + 32'(c * 16));
      end
      hit = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (!hit && resume_at[w] == cyc && n_res < 8) begin
          hit = 1'b1;
          do_resume(w, NT'(w + 1), 32'h0000_2000 + 32'(n_res * 4));
          push_exp(w, NT'(w + 1), 32'h0000_2000 + 32'(n_res * 4));
          n_res++;
        end
      end
      tick();
    end
    idle_inputs();
    wait_drain("rr_drain");
    check("rr_resumes", 64'(n_res), 64'd8);
    check("rr_issue_count", 64'(fire_cnt - f0), 64'd12);

    // Back-pressure: data held for five cycles
    do_reset();
    sif.ready = 1'b0;
    do_spawn(0, NT'(4'h5), 32'h0000_3000);
    push_exp(0, NT'(4'h5), 32'h0000_3000);
    hold_exp = exp_q[0];
    tick();
    idle_inputs();
    for (int i = 0; i < 10 && !sif.valid; i++) tick();
    check("hold_valid_seen", 64'(sif.valid), 64'd1);
    check("perf_idle", perf_idle_cycles, EXP_IDLE);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(sif.valid), 64'd1);
      check("hold_data", 64'(sif.data), 64'(hold_exp));
      tick();
    end
    check("perf_stall", perf_stall_cycles, EXP_STALL);
    sif.ready = 1'b1;
    tick();
    check("perf_stall_after", perf_stall_cycles, EXP_STALL);
    wait_drain("hold_drain");

    // Exit with zero mask
    do_reset();
    f0 = fire_cnt;
    for (int w = 0; w < 4; w++) begin
      do_spawn(w, NT'(4'h3), 32'h0000_4000 + 32'(w * 16));
      push_exp(w, NT'(4'h3), 32'h0000_4000 + 32'(w * 16));
      tick();
    end
    idle_inputs();
    wait_drain("exit_drain");
    do_resume(2, NT'(0), 32'h0000_5000);
    tick();
    idle_inputs();
    repeat (6) tick();
    check("exit_busy_some", 64'(busy), 64'd1);
    do_resume(2, NT'(4'hF), 32'h0000_5100);
    tick();
    for (int k = 0; k < 3; k++) begin
      do_resume((k == 2) ? 3 : k, NT'(0), 32'h0000_5200);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    check("exit_busy_none", 64'(busy), 64'd0);
    check("exit_issue_count", 64'(fire_cnt - f0), 64'd4);

    // Same-cycle spawn and resume, then a duplicate resume
    do_reset();
    f0 = fire_cnt;
    do_spawn(1, NT'(4'h3), 32'h0000_0010);
    push_exp(1, NT'(4'h3), 32'h0000_0010);
    tick();
    idle_inputs();
    wait_drain("collide_first");
    do_spawn(1, NT'(4'h1), 32'h0000_0100);
    do_resume(1, NT'(4'h7), 32'h0000_0200);
    push_exp(1, NT'(4'h7), 32'h0000_0200);
    tick();
    idle_inputs();
    do_resume(1, NT'(4'hF), 32'h0000_0300);
    tick();
    idle_inputs();
    repeat (8) tick();
    check("collide_queue", 64'(exp_q.size()), 64'd0);
    check("collide_issue_count", 64'(fire_cnt - f0), 64'd2);

    // Reset while a stalled issue is pending
    do_reset();
    sif.ready = 1'b0;
    do_spawn(0, NT'(4'h1), 32'h0000_6000);
    tick();
    do_spawn(1, NT'(4'h2), 32'h0000_6100);
    tick();
    idle_inputs();
    for (int i = 0; i < 10 && !sif.valid; i++) tick();
    check("midrst_valid_pre", 64'(sif.valid), 64'd1);
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(sif.valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_uuid  = 0;
    sif.ready = 1'b1;
    f0 = fire_cnt;
    do_spawn(3, NT'(4'h9), 32'h0000_7000);
    push_exp(3, NT'(4'h9), 32'h0000_7000);
    tick();
    idle_inputs();
    wait_drain("midrst_drain");
    check("midrst_issue_count", 64'(fire_cnt - f0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vx_warp_sched_arb.md
VX_WARP_SCHED_ARB -- requirements
Module: VX_warp_sched_arb

Interface
REQ-001 Parameter NUM_WARPS, default `NUM_WARPS, number of warp slots; NW_WIDTH = max(1, clog2(NUM_WARPS)).
REQ-002 Parameter NUM_THREADS, default `NUM_THREADS, thread-mask width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spawn_valid  input  1  activate a warp this cycle.
REQ-006 spawn_wid / spawn_tmask / spawn_PC  input  NW_WIDTH / NUM_THREADS / PC_BITS  warp to activate, with its initial mask and PC.
REQ-007 resume_valid  input  1  return of a previously issued warp.
REQ-008 resume_wid / resume_tmask / resume_PC  input  NW_WIDTH / NUM_THREADS / PC_BITS  warp being returned, its next mask and next PC.
REQ-009 schedule_if  master  VX_schedule_if  issue stream of {uuid, wid, tmask, PC}, with valid/ready.
REQ-010 busy  output  1  high while any warp is active.
REQ-011 perf_stall_cycles / perf_idle_cycles  output  64 / 64  performance counters (see Configuration).

Function
REQ-012 Per-warp state SHALL be active, stalled, tmask and PC; a warp is eligible when active and not stalled.
REQ-013 Output is a one-entry register; it SHALL load when empty or firing (valid && ready) and at least one eligible warp exists.
REQ-014 Selection SHALL be round-robin: the search starts at wid rr_ptr+1, and rr_ptr takes the granted wid on each load.
REQ-015 On load, the granted warp SHALL be marked stalled in the same cycle, so it is never selected twice.
REQ-016 uuid SHALL equal the uuid counter value at load; the counter SHALL increment by 1 per load and wrap modulo 2^UUID_WIDTH.
REQ-017 While valid && !ready, valid and data SHALL hold stable; valid never deasserts without a fire.
REQ-018 Spawn-to-valid latency SHALL be 1 cycle minimum; resume-to-valid latency SHALL be 1 cycle minimum.
REQ-019 A spawn on an inactive warp SHALL set active=1, stalled=0, tmask and PC; a spawn on an active warp is ignored.
REQ-020 A resume on a stalled warp SHALL clear stalled and update tmask and PC; if resume_tmask==0 it SHALL also clear active (warp exits).
REQ-021 A resume on a non-stalled or inactive warp is ignored.
REQ-022 If spawn and resume target the same wid in the same cycle, the resume SHALL win.
REQ-023 Newly spawned or resumed state is not eligible until the cycle after the update (eligibility uses registered state).
REQ-024 busy = OR of active[].

Reset
REQ-025 While reset is high: all active/stalled bits 0, schedule valid 0, data 0, uuid counter 0, rr_ptr = NUM_WARPS-1 (so wid 0 has priority first), perf counters 0.
REQ-026 A reset asserted mid-transaction SHALL drop valid on the next edge regardless of ready; pending warps are discarded.

Configuration
REQ-027 Macro SCHED_PERF_EN: when defined, perf_stall_cycles SHALL count cycles with valid && !ready, and perf_idle_cycles SHALL count cycles with !valid && busy; both saturate at all-ones.
REQ-028 Without SCHED_PERF_EN, both perf ports SHALL exist and be driven to constant 0, and no counter flops are built.

Structure
REQ-029 The issue struct typedef (uuid, wid, tmask, PC) and NW_WIDTH SHALL be defined in VX_gpu_pkg and shared with VX_schedule_if.
REQ-030 Selection SHALL use the existing generic round-robin arbiter sub-module VX_rr_arbiter (NUM_REQS=NUM_WARPS); all other logic lives in this module.

Verification
REQ-031 Reset, then spawn wid 0 (tmask 0xF, PC 0x80000000), ready=1 -> valid on the next cycle with uuid 0, wid 0, tmask 0xF, PC 0x80000000; no second issue until resume.
REQ-032 Spawn wids 0-3, ready=1, each warp resumed 2 cycles after its issue -> issue order 0,1,2,3,0,1..., uuids incrementing 0,1,2,...
REQ-033 Hold ready=0 for 5 cycles with valid high -> data unchanged across all 5 cycles; with SCHED_PERF_EN, perf_stall_cycles = 5.
REQ-034 Resume wid 2 with tmask 0 -> wid 2 never issues again; busy drops once all warps have exited.
REQ-035 Spawn and resume wid 1 in the same cycle (spawn PC 0x100, resume PC 0x200) -> the next issue of wid 1 carries PC 0x200; a duplicate resume to a non-stalled warp is ignored.
REQ-036 Assert reset while valid && !ready -> valid 0 on the next edge, busy 0, uuid counter restarts at 0.
